// File: rtl/rv_mem_responder_if.sv
// rv_mem_responder_if: the core's mem_* bus between a requester (master)
// and a memory target (slave). With RV_MEM_BUS_ERR_EN defined the bus also
// carries the mem_err completion-error pulse.
interface rv_mem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
`ifdef RV_MEM_BUS_ERR_EN
    logic        mem_err;
`endif

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
`ifdef RV_MEM_BUS_ERR_EN
        input  mem_err,
`endif
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
`ifdef RV_MEM_BUS_ERR_EN
        output mem_err,
`endif
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

// File: rtl/rv_mem_responder.sv
// rv_mem_responder: word-organised RAM answering the core's mem_* bus with
// programmable read/write wait states. Writes take priority over reads when
// both are requested; requests are only sampled while idle.
// Optional feature macro: RV_MEM_BUS_ERR_EN adds the mem_err pulse for
// out-of-range accesses and for requests sampled while busy.
module rv_mem_responder #(
    parameter int    DEPTH     = 1024,
    parameter int    RD_LAT    = 2,
    parameter int    WR_LAT    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    rv_mem_responder_if.slave bus
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] RD_CNT = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [3:0] WR_CNT = 4'((WR_LAT > 0) ? WR_LAT - 1 : 0);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          oor_q, oor_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rbusy_q, rbusy_d;
    logic          wbusy_q, wbusy_d;

    logic          commit_en;
    logic          commit_oor;
    logic [AW-1:0] commit_idx;
    logic [31:0]   commit_data;
    logic [3:0]    commit_mask;
    logic          mem_we;

    logic [AW-1:0] in_idx;
    logic          in_oor;
    logic          wr_req;
    logic          unused_addr_bits;

`ifdef RV_MEM_BUS_ERR_EN
    logic          err_q, err_d;
`endif

    assign in_idx           = bus.mem_addr[AW+1:2];
    assign in_oor           = |bus.mem_addr[31:AW+2];
    assign wr_req           = |bus.mem_wmask;
    assign unused_addr_bits = &{1'b0, bus.mem_addr[1:0]};

    // Elaboration-time contents: all zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // Next-state and commit decode for the IDLE / RD_WAIT / WR_WAIT sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        oor_d       = oor_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;
        rbusy_d     = rbusy_q;
        wbusy_d     = wbusy_q;
        commit_en   = 1'b0;
        commit_oor  = oor_q;
        commit_idx  = idx_q;
        commit_data = wdata_q;
        commit_mask = wmask_q;
`ifdef RV_MEM_BUS_ERR_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    idx_d   = in_idx;
                    oor_d   = in_oor;
                    wdata_d = bus.mem_wdata;
                    wmask_d = bus.mem_wmask;
                    if (WR_LAT == 0) begin
                        // Zero wait states: commit straight from the bus on the accept edge.
                        commit_en   = 1'b1;
                        commit_oor  = in_oor;
                        commit_idx  = in_idx;
                        commit_data = bus.mem_wdata;
                        commit_mask = bus.mem_wmask;
`ifdef RV_MEM_BUS_ERR_EN
                        err_d       = in_oor;
`endif
                    end else begin
                        wbusy_d = 1'b1;
                        cnt_d   = WR_CNT;
                        state_d = WR_WAIT;
                    end
                end else if (bus.mem_rstrb) begin
                    idx_d = in_idx;
                    oor_d = in_oor;
                    if (RD_LAT == 0) begin
                        rdata_d = in_oor ? 32'h0 : mem[in_idx];
`ifdef RV_MEM_BUS_ERR_EN
                        err_d   = in_oor;
`endif
                    end else begin
                        rbusy_d = 1'b1;
                        cnt_d   = RD_CNT;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = oor_q ? 32'h0 : mem[idx_q];
                    rbusy_d = 1'b0;
                    state_d = IDLE;
`ifdef RV_MEM_BUS_ERR_EN
                    err_d   = oor_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit_en = 1'b1;
                    wbusy_d   = 1'b0;
                    state_d   = IDLE;
`ifdef RV_MEM_BUS_ERR_EN
                    err_d     = oor_q;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RV_MEM_BUS_ERR_EN
        // A request that arrives while busy is dropped and flagged one cycle later.
        if (state_q != IDLE && (wr_req || bus.mem_rstrb)) err_d = 1'b1;
`endif
    end

    // Out-of-range writes are dropped; holding reset blocks any commit, so an aborted write never lands.
    assign mem_we = commit_en & ~commit_oor & reset;

    // Sequencer, latched request and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
`ifdef RV_MEM_BUS_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
            wbusy_q <= wbusy_d;
`ifdef RV_MEM_BUS_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Byte-lane write port of the storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; contents survive a reset.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (commit_mask[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_rbusy = rbusy_q;
    assign bus.mem_wbusy = wbusy_q;
`ifdef RV_MEM_BUS_ERR_EN
    assign bus.mem_err   = err_q;
`endif
endmodule

// File: tb/tb_rv_mem_responder.sv
// tb_rv_mem_responder: three responders with different wait-state settings,
// driven one at a time through a shared set of request signals and compared
// against a word-array model of memory contents and latencies.
module tb_rv_mem_responder;
    localparam int NDUT = 3;

    // Per-instance configuration: A = default latencies, B = zero latency, C = long write.
    int depth_c  [NDUT] = '{1024, 16, 64};
    int rd_lat_c [NDUT] = '{2, 0, 1};
    int wr_lat_c [NDUT] = '{1, 0, 3};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    int          sel;

    rv_mem_responder_if bus_a ();
    rv_mem_responder_if bus_b ();
    rv_mem_responder_if bus_c ();

    assign bus_a.mem_addr  = addr;
    assign bus_a.mem_wdata = wdata;
    assign bus_a.mem_wmask = (sel == 0) ? wmask : 4'h0;
    assign bus_a.mem_rstrb = (sel == 0) && rstrb;
    assign bus_b.mem_addr  = addr;
    assign bus_b.mem_wdata = wdata;
    assign bus_b.mem_wmask = (sel == 1) ? wmask : 4'h0;
    assign bus_b.mem_rstrb = (sel == 1) && rstrb;
    assign bus_c.mem_addr  = addr;
    assign bus_c.mem_wdata = wdata;
    assign bus_c.mem_wmask = (sel == 2) ? wmask : 4'h0;
    assign bus_c.mem_rstrb = (sel == 2) && rstrb;

    rv_mem_responder #(.DEPTH(1024), .RD_LAT(2), .WR_LAT(1), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    rv_mem_responder #(.DEPTH(16), .RD_LAT(0), .WR_LAT(0), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));
    rv_mem_responder #(.DEPTH(64), .RD_LAT(1), .WR_LAT(3), .INIT_FILE("")) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    // Outputs of the currently selected instance.
    logic [31:0] rdata_m;
    logic        rbusy_m, wbusy_m;
    always_comb begin
        rdata_m = bus_a.mem_rdata;
        rbusy_m = bus_a.mem_rbusy;
        wbusy_m = bus_a.mem_wbusy;
        case (sel)
            1: begin rdata_m = bus_b.mem_rdata; rbusy_m = bus_b.mem_rbusy; wbusy_m = bus_b.mem_wbusy; end
            2: begin rdata_m = bus_c.mem_rdata; rbusy_m = bus_c.mem_rbusy; wbusy_m = bus_c.mem_wbusy; end
            default: ;
        endcase
    end

`ifdef RV_MEM_BUS_ERR_EN
    int err_cnt_a = 0;
    always @(negedge clk) if (bus_a.mem_err === 1'b1) err_cnt_a++;
`endif

    // Reference model: memory words and the last read value of each instance.
    logic [31:0] ref_mem   [NDUT][1024];
    logic [31:0] exp_rdata [NDUT];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // One bus transaction: pulse the request, count busy cycles, check latency and read data.
    task automatic access(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic rs, input string tag);
        int  busy_n;
        bit  is_wr;
        bit  oor;
        int  exp_lat;
        is_wr   = (m != 4'h0);
        oor     = (a >= 32'(4 * depth_c[s]));
        exp_lat = is_wr ? wr_lat_c[s] : rd_lat_c[s];
        if (is_wr) begin
            if (!oor) ref_mem[s][a >> 2] = merge(ref_mem[s][a >> 2], d, m);
        end else begin
            exp_rdata[s] = oor ? 32'h0 : ref_mem[s][a >> 2];
        end
        @(negedge clk);
        sel = s; addr = a; wdata = d; wmask = m; rstrb = rs;
        @(negedge clk);
        wmask = 4'h0; rstrb = 1'b0;
        busy_n = 0;
        while ((is_wr ? wbusy_m : rbusy_m) && busy_n < 40) begin
            busy_n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_rdata"}, rdata_m, exp_rdata[s]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [3:0]  m;
        int          busy_n;
`ifdef RV_MEM_BUS_ERR_EN
        int          e0;
`endif
        for (int s = 0; s < NDUT; s++) begin
            exp_rdata[s] = 32'h0;
            for (int i = 0; i < 1024; i++) ref_mem[s][i] = 32'h0;
        end
        reset = 1'b0; addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0; sel = 0;

        // Reset values of every instance.
        #12;
        for (int s = 0; s < NDUT; s++) begin
            sel = s; #1;
            check("rst_rdata", rdata_m, 32'h0);
            check("rst_rbusy", 32'(rbusy_m), 32'h0);
            check("rst_wbusy", 32'(wbusy_m), 32'h0);
        end
`ifdef RV_MEM_BUS_ERR_EN
        check("rst_err", 32'(bus_a.mem_err), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Default latencies: program word 0 then read it back after two busy cycles.
        access(0, 32'h0, 32'h0020_0093, 4'hF, 1'b0, "a_wr0");
        access(0, 32'h0, 32'h0, 4'h0, 1'b1, "a_rd0");
        check("a_rd0_const", rdata_m, 32'h0020_0093);

        // Full-word store then a single byte lane.
        access(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "a_wr10");
        access(0, 32'h10, 32'h0, 4'h0, 1'b1, "a_rd10");
        check("a_rd10_const", rdata_m, 32'hDEAD_BEEF);
        access(0, 32'h10, 32'h0055_0000, 4'b0100, 1'b0, "a_lane");
        access(0, 32'h10, 32'h0, 4'h0, 1'b1, "a_rdlane");
        check("a_lane_const", rdata_m, 32'hDE55_BEEF);

        // Write and read requested together: the write wins, rdata holds.
        access(0, 32'h14, 32'h1357_9BDF, 4'hF, 1'b1, "a_both");
        access(0, 32'h14, 32'h0, 4'h0, 1'b1, "a_rdboth");

        // A write sampled during a read's wait states is ignored.
        exp_rdata[0] = ref_mem[0][4];
        @(negedge clk);
        sel = 0; addr = 32'h10; rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0; wmask = 4'hF; wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        wmask = 4'h0;
        busy_n = 0;
        while (rbusy_m && busy_n < 40) begin busy_n++; @(negedge clk); end
        check("a_busy_ignored_lat", 32'(busy_n), 32'd1);
        check("a_busy_ignored_rdata", rdata_m, exp_rdata[0]);
        access(0, 32'h10, 32'h0, 4'h0, 1'b1, "a_busy_ignored_rd");

        // Out of range on the 1024-word instance.
`ifdef RV_MEM_BUS_ERR_EN
        @(negedge clk); #1;
        e0 = err_cnt_a;
`endif
        access(0, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, "a_oor_wr");
        access(0, 32'h1000, 32'h0, 4'h0, 1'b1, "a_oor_rd");
        check("a_oor_const", rdata_m, 32'h0);
        access(0, 32'h0, 32'h0, 4'h0, 1'b1, "a_oor_w0");
        check("a_oor_w0_const", rdata_m, 32'h0020_0093);
`ifdef RV_MEM_BUS_ERR_EN
        @(negedge clk); #1;
        check("a_oor_err_pulses", 32'(err_cnt_a - e0), 32'd2);
`endif

        // Zero latency: back-to-back writes then back-to-back reads of 0,4,8,C.
        @(negedge clk);
        sel = 1;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            addr = 32'(4 * i); wdata = v; wmask = 4'hF;
            ref_mem[1][i] = v;
            @(negedge clk);
            check("b_b2b_wbusy", 32'(wbusy_m), 32'h0);
        end
        wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(4 * i); rstrb = 1'b1;
            @(negedge clk);
            check("b_b2b_rdata", rdata_m, ref_mem[1][i]);
            check("b_b2b_rbusy", 32'(rbusy_m), 32'h0);
        end
        rstrb = 1'b0;
        exp_rdata[1] = ref_mem[1][3];

        // Randomized traffic on every instance, including out-of-range addresses.
        for (int s = 0; s < NDUT; s++) begin
            for (int n = 0; n < 30; n++) begin
                a = 32'(4 * $urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) a = a + 32'(4 * depth_c[s]);
                if ($urandom_range(0, 1) == 1) begin
                    m = 4'($urandom_range(1, 15));
                    access(s, a, $urandom, m, 1'b0, "rnd_wr");
                end else begin
                    access(s, a, 32'h0, 4'h0, 1'b1, "rnd_rd");
                end
            end
        end

        // Reset in the second busy cycle of a three-cycle write aborts it.
        access(2, 32'h20, 32'h1111_2222, 4'hF, 1'b0, "c_prior");
        @(negedge clk);
        sel = 2; addr = 32'h20; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        @(negedge clk);
        wmask = 4'h0;
        check("c_mid_wbusy1", 32'(wbusy_m), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("c_mid_wbusy_abort", 32'(wbusy_m), 32'h0);
        check("c_mid_rdata_rst", rdata_m, 32'h0);
        for (int s = 0; s < NDUT; s++) exp_rdata[s] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        access(2, 32'h20, 32'h0, 4'h0, 1'b1, "c_after_abort");
        check("c_after_abort_const", rdata_m, 32'h1111_2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_mem_responder.md
Name: rv_mem_responder

Overview:
- Word-organised memory target: the responder end of the core's `mem_*` bus.
- Serves instruction fetches and loads via `mem_rstrb`/`mem_rdata`/`mem_rbusy`, and byte-masked stores via `mem_wmask`/`mem_wdata`/`mem_wbusy`.
- Inserts programmable wait states so core stall handling is exercised in RTL, not forced by a bench.
- Replaces hand-driven `mem_rdata` in core-level simulation and is the on-chip program/data RAM in the SoC top.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, min 4.
- RD_LAT, 2, read wait cycles (0..15).
- WR_LAT, 1, write wait cycles (0..15).
- INIT_FILE, "", hex image loaded at elaboration; empty means contents are all zero.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- mem_addr  in  32  byte address; word index = mem_addr[log2(DEPTH)+1:2]; bits [1:0] ignored
- mem_wdata  in  32  store data, byte lanes aligned to mask
- mem_wmask  in  4  byte write enables; nonzero for one cycle = write request
- mem_rstrb  in  1  one-cycle read request
- mem_rdata  out  32  read data
- mem_rbusy  out  1  read in progress
- mem_wbusy  out  1  write in progress

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, mem_rdata=0, mem_rbusy=0, mem_wbusy=0. Array contents are not cleared.
- FSM has three states: IDLE, RD_WAIT, WR_WAIT. Requests are sampled only in IDLE; requests arriving in any other state are ignored.
- IDLE, mem_wmask!=0 (write has priority):
  - Latch addr, wdata and mask.
  - WR_LAT=0: commit the enabled bytes on this edge; stay IDLE; mem_wbusy stays 0.
  - Otherwise: mem_wbusy<=1, counter<=WR_LAT-1, go to WR_WAIT.
- IDLE, mem_wmask==0 and mem_rstrb=1:
  - Latch addr.
  - RD_LAT=0: mem_rdata<=word on this edge; mem_rbusy stays 0.
  - Otherwise: mem_rbusy<=1, counter<=RD_LAT-1, go to RD_WAIT.
- Simultaneous rstrb and nonzero wmask: the write is served and the read is dropped. The core never issues both, so this behaviour is defined but not relied on.
- RD_WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0: mem_rdata<=mem[latched idx], mem_rbusy<=0, go to IDLE.
  - Result: rbusy is high for exactly RD_LAT cycles and data is valid in the first cycle rbusy is low.
- WR_WAIT: same counting. On the edge where counter==0, commit the enabled bytes, mem_wbusy<=0, go to IDLE.
- mem_rdata holds its last value between reads and is never changed by writes.
- Read of an address just written returns the new data; the write is committed before IDLE re-accepts.
- Out of range (address bits above the index nonzero):
  - Read returns 32'h0000_0000 with the normal latency.
  - Write is dropped, with the normal wbusy timing.
- Reset mid-operation aborts: busy flags go low immediately, and a pending write is not committed.
- Back-to-back: a new request is accepted in the first IDLE cycle after busy deasserts. Zero-latency requests are accepted every cycle.

Optional Feature:
- Macro: RV_MEM_BUS_ERR_EN.
- When defined:
  - Adds output `mem_err` (1 bit, reset 0).
  - `mem_err` pulses high for one cycle, coincident with completion (busy falling, or the accept edge when latency is 0), for any out-of-range access.
  - It also pulses one cycle after any request sampled while not IDLE.
- When undefined: no port, no logic; those conditions are silently ignored as described above.

Test Plan:
- Reset with INIT_FILE word0=32'h0020_0093, RD_LAT=2; rstrb at addr 0 → rbusy high 2 cycles, then mem_rdata=32'h0020_0093 with rbusy=0.
- WR_LAT=1: wmask=4'b1111, addr 0x10, wdata 32'hDEAD_BEEF; then read 0x10 → wbusy high 1 cycle; read returns 32'hDEAD_BEEF.
- Byte lanes: wmask=4'b0100, wdata 32'h0055_0000 over 32'hDEAD_BEEF at 0x10 → read returns 32'hDE55_BEEF.
- RD_LAT=0/WR_LAT=0: rstrb on 4 consecutive cycles at addrs 0,4,8,C → rbusy never asserts; rdata updates every cycle in address order.
- Out of range: DEPTH=1024, write 32'h1234_5678 to 0x1000, then read 0x1000 and 0x0 → 0x1000 reads 0; word 0 unchanged; with RV_MEM_BUS_ERR_EN, mem_err pulses twice.
- Reset mid-write: WR_LAT=3, write 32'hFFFF_FFFF to 0x20, pull reset low in the 2nd busy cycle → wbusy=0 immediately; subsequent read of 0x20 returns the prior value.
